// File: rtl/memory_arbiter_pkg.sv
// Shared encodings and defaults for the instruction/data cache memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  localparam int DEF_ADDRESS_SIZE    = 12;
  localparam int DEF_CACHE_LINE_SIZE = 128;

endpackage

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Two-input round-robin grant: one-hot grant, ties go to the port that did not win last.
module rr_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == ICACHE) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one Memory block between icache (read-only) and dcache (read/write), round-robin.
// Optional ISSUE watchdog enabled by defining MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE    = DEF_ADDRESS_SIZE,
  parameter int CACHE_LINE_SIZE = DEF_CACHE_LINE_SIZE,
  parameter int TIMEOUT_CYCLES  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ic_req,
  input  logic [ADDRESS_SIZE-1:0]    ic_addr,
  output logic [CACHE_LINE_SIZE-1:0] ic_rdata,
  output logic                       ic_valid,
  input  logic                       dc_req,
  input  logic                       dc_op,
  input  logic [ADDRESS_SIZE-1:0]    dc_addr,
  input  logic [CACHE_LINE_SIZE-1:0] dc_wdata,
  output logic [CACHE_LINE_SIZE-1:0] dc_rdata,
  output logic                       dc_valid,
  output logic                       resp_err,
  output logic                       mem_enable,
  output logic                       mem_op,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  output logic                       mem_op_init,
  output logic                       mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready
);

  state_e                     state_q;
  logic                       last_grant_q;
  logic                       cur_port_q;
  logic                       rel_first_q;
  logic [CACHE_LINE_SIZE-1:0] ic_rdata_q;
  logic [CACHE_LINE_SIZE-1:0] dc_rdata_q;
  logic                       ic_valid_q;
  logic                       dc_valid_q;
  logic                       mem_enable_q;
  logic                       mem_op_q;
  logic [ADDRESS_SIZE-1:0]    mem_address_q;
  logic [CACHE_LINE_SIZE-1:0] mem_data_in_q;
  logic                       mem_op_init_q;
  logic                       mem_op_done_q;
  logic [1:0]                 grant_d;

  rr_arbiter_2 u_rr (
    .req_i        ({dc_req, ic_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_d)
  );

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          resp_err_q;
  assign resp_err = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= DCACHE;
      cur_port_q    <= ICACHE;
      rel_first_q   <= 1'b0;
      ic_rdata_q    <= '0;
      dc_rdata_q    <= '0;
      ic_valid_q    <= 1'b0;
      dc_valid_q    <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_op_q      <= MEM_OP_READ;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_op_init_q <= 1'b0;
      mem_op_done_q <= 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      resp_err_q    <= 1'b0;
`endif
    end else begin
      ic_valid_q    <= 1'b0;
      dc_valid_q    <= 1'b0;
      mem_op_init_q <= 1'b0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      resp_err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A ready left over from an aborted or timed-out op must be retired first.
          if (mem_data_ready) begin
            mem_op_done_q <= 1'b1;
          end else begin
            mem_op_done_q <= 1'b0;
            if (grant_d != 2'b00) begin
              cur_port_q    <= grant_d[1];
              last_grant_q  <= grant_d[1];
              mem_enable_q  <= 1'b1;
              mem_op_init_q <= 1'b1;
              mem_op_q      <= grant_d[1] ? dc_op    : MEM_OP_READ;
              mem_address_q <= grant_d[1] ? dc_addr  : ic_addr;
              mem_data_in_q <= grant_d[1] ? dc_wdata : '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
              tmo_cnt_q     <= '0;
`endif
              state_q       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_data_ready) begin
            if (cur_port_q == DCACHE) begin
              dc_rdata_q <= mem_data_out;
              dc_valid_q <= 1'b1;
            end else begin
              ic_rdata_q <= mem_data_out;
              ic_valid_q <= 1'b1;
            end
            mem_enable_q  <= 1'b0;
            mem_op_done_q <= 1'b1;
            rel_first_q   <= 1'b1;
            state_q       <= RELEASE;
          end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            if (cur_port_q == DCACHE) begin
              dc_rdata_q <= '0;
              dc_valid_q <= 1'b1;
            end else begin
              ic_rdata_q <= '0;
              ic_valid_q <= 1'b1;
            end
            resp_err_q   <= 1'b1;
            mem_enable_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Minimum two cycles so the served requester has dropped req before IDLE.
          rel_first_q <= 1'b0;
          if (!rel_first_q && !mem_data_ready) begin
            mem_op_done_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_rdata    = ic_rdata_q;
  assign ic_valid    = ic_valid_q;
  assign dc_rdata    = dc_rdata_q;
  assign dc_valid    = dc_valid_q;
  assign mem_enable  = mem_enable_q;
  assign mem_op      = mem_op_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_op_init = mem_op_init_q;
  assign mem_op_done = mem_op_done_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural Memory (byte k of a line = address low byte).
module tb_memory_arbiter;

  localparam int AW  = 12;
  localparam int LW  = 128;
  localparam int OPD = 3;

  logic          clk;
  logic          rst_n;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [LW-1:0] ic_rdata;
  logic          ic_valid;
  logic          dc_req;
  logic          dc_op;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic [LW-1:0] dc_rdata;
  logic          dc_valid;
  logic          resp_err;
  logic          mem_enable;
  logic          mem_op;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic          mem_op_init;
  logic          mem_op_done;
  logic [LW-1:0] mem_data_out = '0;
  logic          mem_data_ready = 1'b0;

  memory_arbiter #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_valid(ic_valid),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_valid(dc_valid), .resp_err(resp_err),
    .mem_enable(mem_enable), .mem_op(mem_op), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_op_init(mem_op_init), .mem_op_done(mem_op_done),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Memory: op_init starts an op, ready after OPD counts, held until op_done.
  logic [7:0]    memb [0:4095];
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic          m_op = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] rd_line;
  logic          mute = 1'b0;

  initial for (int i = 0; i < 4096; i++) memb[i] = i[7:0];

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_cnt == OPD) begin
        for (int k = 0; k < 16; k++) begin
          if (m_op) memb[int'(m_addr) + k] = m_wdata[8*k +: 8];
          rd_line[8*k +: 8] = memb[int'(m_addr) + k];
        end
        mem_data_out   <= rd_line;
        mem_data_ready <= 1'b1;
        m_busy         <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (mem_data_ready) begin
      if (mem_op_done) mem_data_ready <= 1'b0;
    end else if (mem_op_init && mem_enable && !mute) begin
      m_busy  <= 1'b1;
      m_cnt   <= 1;
      m_op    <= mem_op;
      m_addr  <= mem_address;
      m_wdata <= mem_data_in;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_tests++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input logic port, input logic op, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, output logic [LW-1:0] rd, output int lat,
                         output int nval, output logic op_bad, output logic err);
    int gstart;
    gstart = -100; rd = '0; lat = 999; nval = 0; op_bad = 1'b0; err = 1'b0;
    @(negedge clk);
    if (port) begin
      dc_req = 1'b1; dc_op = op; dc_addr = addr; dc_wdata = wd;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mem_op_init) gstart = c;
      if (mem_enable && (mem_op !== (port ? op : 1'b0))) op_bad = 1'b1;
      if (port ? dc_valid : ic_valid) begin
        nval++;
        if (nval == 1) begin
          rd  = port ? dc_rdata : ic_rdata;
          lat = c - gstart;
          err = resp_err;
        end
        if (port) dc_req = 1'b0; else ic_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
  endtask

  typedef struct {
    logic          port;
    logic          op;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp;
    logic          chk_rd;
    string         name;
  } vec_t;

  vec_t          vecs [6];
  logic [LW-1:0] rd;
  int            lat;
  int            nval;
  logic          op_bad;
  logic          err;
  int            order [4];
  int            n_gr;
  int            ic_cnt, dc_cnt;
  logic          ic_off, dc_off;
  logic          seen;
  int            nv;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 12'h010, '0, 128'h1f1e1d1c1b1a19181716151413121110, 1'b1, "ic_rd_010"};
    vecs[1] = '{1'b1, 1'b1, 12'h040, 128'h00112233445566778899AABBCCDDEEFF, '0, 1'b0, "dc_wr_040"};
    vecs[2] = '{1'b1, 1'b0, 12'h040, '0, 128'h00112233445566778899AABBCCDDEEFF, 1'b1, "dc_rd_040"};
    vecs[3] = '{1'b0, 1'b0, 12'h040, '0, 128'h00112233445566778899AABBCCDDEEFF, 1'b1, "ic_rd_040"};
    vecs[4] = '{1'b1, 1'b0, 12'h000, '0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, "dc_rd_000"};
    vecs[5] = '{1'b0, 1'b0, 12'h0F0, '0, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 1'b1, "ic_rd_0f0"};

    rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_op = 1'b0; dc_addr = '0; dc_wdata = '0;
    do_reset(3);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_op_init", mem_op_init, 0);
    check("rst_mem_op_done", mem_op_done, 0);
    check("rst_valids", {ic_valid, dc_valid}, 0);
    check("rst_ic_rdata", ic_rdata, 0);
    check("rst_dc_rdata", dc_rdata, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_resp_err", resp_err, 0);

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].port, vecs[v].op, vecs[v].addr, vecs[v].wdata, rd, lat, nval, op_bad, err);
      check({vecs[v].name, "_nvalid"}, nval, 1);
      check_le({vecs[v].name, "_latency"}, lat, 8);
      check({vecs[v].name, "_mem_op"}, op_bad, 0);
      check({vecs[v].name, "_resp_err"}, err, 0);
      if (vecs[v].chk_rd) check({vecs[v].name, "_rdata"}, rd, vecs[v].exp);
    end

    // Collision with both requesters re-raising after each response: IC, DC, IC, DC.
    do_reset(2);
    @(negedge clk);
    ic_addr = 12'h0C0; dc_addr = 12'h080; dc_op = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    n_gr = 0; ic_cnt = 0; dc_cnt = 0; ic_off = 1'b0; dc_off = 1'b0;
    for (int c = 0; c < 80 && n_gr < 4; c++) begin
      @(negedge clk);
      if (ic_off) begin ic_off = 1'b0; if (ic_cnt < 2) ic_req = 1'b1; end
      if (dc_off) begin dc_off = 1'b0; if (dc_cnt < 2) dc_req = 1'b1; end
      if (ic_valid) begin order[n_gr] = 0; n_gr++; ic_cnt++; ic_req = 1'b0; ic_off = 1'b1; end
      if (dc_valid) begin order[n_gr] = 1; n_gr++; dc_cnt++; dc_req = 1'b0; dc_off = 1'b1; end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    check("coll_grants", n_gr, 4);
    check("coll_first_ic", order[0], 0);
    check("coll_second_dc", order[1], 1);
    check("coll_third_ic", order[2], 0);
    check("coll_fourth_dc", order[3], 1);
    repeat (8) @(negedge clk);

    // Reset while in ISSUE, then flush the stale ready and serve a fresh request.
    do_reset(2);
    @(negedge clk);
    ic_addr = 12'h020; ic_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_op_init) seen = 1'b1;
    end
    check("midrst_grant_seen", seen, 1);
    @(negedge clk);
    rst_n = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_outputs_zero",
          {mem_enable, mem_op_init, mem_op_done, ic_valid, dc_valid, mem_op, resp_err}, 0);
    check("midrst_addr_zero", mem_address, 0);
    nv = 0; seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ic_valid || dc_valid) nv++;
      if (mem_data_ready && mem_op_done && !mem_enable) seen = 1'b1;
    end
    check("midrst_no_valid", nv, 0);
    check("midrst_stale_flushed", seen, 1);
    check("midrst_ready_clear", mem_data_ready, 0);
    run_txn(1'b0, 1'b0, 12'h020, '0, rd, lat, nval, op_bad, err);
    check("post_rst_nvalid", nval, 1);
    check("post_rst_rdata", rd, 128'h2f2e2d2c2b2a29282726252423222120);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    mute = 1'b1;
    run_txn(1'b1, 1'b0, 12'h030, '0, rd, lat, nval, op_bad, err);
    check("tmo_latency", lat, 8);
    check("tmo_resp_err", err, 1);
    check("tmo_rdata_zero", rd, 0);
    check("tmo_nvalid", nval, 1);
    check("tmo_enable_low", mem_enable, 0);
    mute = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
